// File: rtl/fifo_mem_dp_pipe.sv
// Simple dual-port FIFO storage array with byte-enable writes and a 1- or 2-cycle registered read.
// Optional per-lane parity storage and checking is enabled by defining FIFO_MEM_PARITY_EN.
module fifo_mem_dp_pipe #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int BYTE_WIDTH = 8,
   parameter int RD_LATENCY = 1,
   parameter int RDW_MODE   = 0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             wr_en,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
   input  logic [ADDR_WIDTH-1:0]            waddr,
   input  logic [DATA_WIDTH-1:0]            wr_data,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_par_flip,
   input  logic                             rd_en,
   input  logic [ADDR_WIDTH-1:0]            raddr,
   output logic [DATA_WIDTH-1:0]            rd_data,
   output logic                             rd_valid,
   output logic                             rd_par_err
);

   localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   if (!((RD_LATENCY == 32'sd1) || (RD_LATENCY == 32'sd2))) begin : g_bad_latency
      $error("fifo_mem_dp_pipe: RD_LATENCY must be 1 or 2");
   end
   if ((DATA_WIDTH % BYTE_WIDTH) != 32'sd0) begin : g_bad_width
      $error("fifo_mem_dp_pipe: DATA_WIDTH must be a multiple of BYTE_WIDTH");
   end

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic                  wr_acc_s;
   logic                  rd_acc_s;
   logic                  fwd_s;
   logic [DATA_WIDTH-1:0] rd_word_s;
   logic                  rd_err_s;
   logic                  pre_valid_s;
   logic [DATA_WIDTH-1:0] pre_data_s;
   logic                  pre_err_s;

   assign wr_acc_s = wr_en & ~rst;
   assign rd_acc_s = rd_en & ~rst;
   assign fwd_s    = (RDW_MODE == 32'sd1) && wr_acc_s && rd_acc_s && (waddr == raddr);

   // Byte-lane write port; array contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_acc_s) begin
         for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) begin
               mem_r[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   // Read word with optional write-through merge of the lanes being written.
   always_comb begin
      rd_word_s = mem_r[raddr];
      for (int i = 0; i < NB; i++) begin
         if (fwd_s && wr_be[i]) begin
            rd_word_s[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
         end else begin
            rd_word_s[i*BYTE_WIDTH +: BYTE_WIDTH] = mem_r[raddr][i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

`ifdef FIFO_MEM_PARITY_EN
   function automatic logic even_par(input logic [BYTE_WIDTH-1:0] lane);
      return ^lane;
   endfunction

   logic [NB-1:0] par_mem_r [DEPTH];
   logic [NB-1:0] rd_par_s;

   // Parity side-array, written lane-by-lane alongside the data.
   always_ff @(posedge clk) begin
      if (wr_acc_s) begin
         for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) begin
               par_mem_r[waddr][i] <= even_par(wr_data[i*BYTE_WIDTH +: BYTE_WIDTH]) ^ wr_par_flip[i];
            end
         end
      end
   end

   // Forwarded lanes carry the incoming parity; the rest use the stored bit.
   always_comb begin
      rd_par_s = par_mem_r[raddr];
      rd_err_s = 1'b0;
      for (int i = 0; i < NB; i++) begin
         if (fwd_s && wr_be[i]) begin
            rd_par_s[i] = even_par(wr_data[i*BYTE_WIDTH +: BYTE_WIDTH]) ^ wr_par_flip[i];
         end else begin
            rd_par_s[i] = par_mem_r[raddr][i];
         end
         rd_err_s = rd_err_s | (even_par(rd_word_s[i*BYTE_WIDTH +: BYTE_WIDTH]) ^ rd_par_s[i]);
      end
   end
`else
   logic unused_par_s;
   assign unused_par_s = ^wr_par_flip;
   assign rd_err_s     = 1'b0;
`endif

   if (RD_LATENCY == 32'sd2) begin : g_lat2
      logic                  s1_valid_r;
      logic [DATA_WIDTH-1:0] s1_data_r;
      logic                  s1_err_r;

      // Stage-1 capture: the word is frozen here, so later writes cannot disturb it.
      always_ff @(posedge clk) begin
         if (rst) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= {DATA_WIDTH{1'b0}};
            s1_err_r   <= 1'b0;
         end else begin
            s1_valid_r <= rd_acc_s;
            if (rd_acc_s) begin
               s1_data_r <= rd_word_s;
               s1_err_r  <= rd_err_s;
            end
         end
      end

      assign pre_valid_s = s1_valid_r;
      assign pre_data_s  = s1_data_r;
      assign pre_err_s   = s1_err_r;
   end else begin : g_lat1
      assign pre_valid_s = rd_acc_s;
      assign pre_data_s  = rd_word_s;
      assign pre_err_s   = rd_err_s;
   end

   // Output register: data holds between results, valid and error pulse per read.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data    <= {DATA_WIDTH{1'b0}};
         rd_valid   <= 1'b0;
         rd_par_err <= 1'b0;
      end else begin
         rd_valid   <= pre_valid_s;
         rd_par_err <= pre_valid_s & pre_err_s;
         if (pre_valid_s) begin
            rd_data <= pre_data_s;
         end
      end
   end

endmodule

// File: tb/tb_fifo_mem_dp_pipe.sv
// Directed bench: an 8-bit/latency-1/old-data instance and a 16-bit/latency-2/write-through instance.
module tb_fifo_mem_dp_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;

   logic        a_wr_en;
   logic [0:0]  a_wr_be;
   logic [3:0]  a_waddr;
   logic [7:0]  a_wr_data;
   logic [0:0]  a_wr_par_flip;
   logic        a_rd_en;
   logic [3:0]  a_raddr;
   logic [7:0]  a_rd_data;
   logic        a_rd_valid;
   logic        a_rd_par_err;

   logic        b_wr_en;
   logic [1:0]  b_wr_be;
   logic [3:0]  b_waddr;
   logic [15:0] b_wr_data;
   logic [1:0]  b_wr_par_flip;
   logic        b_rd_en;
   logic [3:0]  b_raddr;
   logic [15:0] b_rd_data;
   logic        b_rd_valid;
   logic        b_rd_par_err;

   int checks   = 0;
   int failures = 0;

`ifdef FIFO_MEM_PARITY_EN
   localparam logic PAR_EXP = 1'b1;
`else
   localparam logic PAR_EXP = 1'b0;
`endif

   fifo_mem_dp_pipe #(
      .ADDR_WIDTH(4), .DATA_WIDTH(8), .BYTE_WIDTH(8), .RD_LATENCY(1), .RDW_MODE(0)
   ) dut_a (
      .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_be(a_wr_be), .waddr(a_waddr),
      .wr_data(a_wr_data), .wr_par_flip(a_wr_par_flip), .rd_en(a_rd_en), .raddr(a_raddr),
      .rd_data(a_rd_data), .rd_valid(a_rd_valid), .rd_par_err(a_rd_par_err)
   );

   fifo_mem_dp_pipe #(
      .ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8), .RD_LATENCY(2), .RDW_MODE(1)
   ) dut_b (
      .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_be(b_wr_be), .waddr(b_waddr),
      .wr_data(b_wr_data), .wr_par_flip(b_wr_par_flip), .rd_en(b_rd_en), .raddr(b_raddr),
      .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_par_err(b_rd_par_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_write(input logic [3:0] addr, input logic [7:0] data);
      a_wr_en = 1'b1; a_waddr = addr; a_wr_data = data; a_wr_be = 1'b1;
      tick();
      a_wr_en = 1'b0;
   endtask

   task automatic a_read(input logic [3:0] addr);
      a_rd_en = 1'b1; a_raddr = addr;
      tick();
      a_rd_en = 1'b0;
   endtask

   task automatic b_write(input logic [3:0] addr, input logic [15:0] data,
                          input logic [1:0] be, input logic [1:0] flip);
      b_wr_en = 1'b1; b_waddr = addr; b_wr_data = data; b_wr_be = be; b_wr_par_flip = flip;
      tick();
      b_wr_en = 1'b0; b_wr_par_flip = 2'b00;
   endtask

   task automatic b_read(input logic [3:0] addr);
      b_rd_en = 1'b1; b_raddr = addr;
      tick();
      b_rd_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      a_wr_en = 1'b0; a_wr_be = 1'b0; a_waddr = 4'd0; a_wr_data = 8'h00; a_wr_par_flip = 1'b0;
      b_wr_en = 1'b0; b_wr_be = 2'b00; b_waddr = 4'd0; b_wr_data = 16'h0000; b_wr_par_flip = 2'b00;
      a_rd_en = 1'b1; a_raddr = 4'd0;
      b_rd_en = 1'b1; b_raddr = 4'd0;

      // Reads requested during reset are ignored.
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rst_a_data",  32'(a_rd_data),    32'h0);
         check("rst_a_valid", 32'(a_rd_valid),   32'h0);
         check("rst_a_perr",  32'(a_rd_par_err), 32'h0);
         check("rst_b_data",  32'(b_rd_data),    32'h0);
         check("rst_b_valid", 32'(b_rd_valid),   32'h0);
         check("rst_b_perr",  32'(b_rd_par_err), 32'h0);
      end
      rst = 1'b0; a_rd_en = 1'b0; b_rd_en = 1'b0;
      tick();
      check("rel_a_valid", 32'(a_rd_valid), 32'h0);
      check("rel_b_valid", 32'(b_rd_valid), 32'h0);
      tick();
      check("rel2_b_valid", 32'(b_rd_valid), 32'h0);

      // Basic write/read, single valid pulse and hold.
      a_write(4'd3, 8'hA5);
      a_read(4'd3);
      check("a_rd3_data",  32'(a_rd_data),  32'hA5);
      check("a_rd3_valid", 32'(a_rd_valid), 32'h1);
      tick();
      check("a_rd3_pulse", 32'(a_rd_valid), 32'h0);
      check("a_rd3_hold",  32'(a_rd_data),  32'hA5);

      // wr_en with no lanes enabled changes nothing.
      a_wr_en = 1'b1; a_waddr = 4'd3; a_wr_data = 8'hFF; a_wr_be = 1'b0;
      tick();
      a_wr_en = 1'b0;
      a_read(4'd3);
      check("a_be0_noop", 32'(a_rd_data), 32'hA5);

      // Top address followed by address 0, back to back.
      a_write(4'd15, 8'h3C);
      a_write(4'd0,  8'hC3);
      a_rd_en = 1'b1; a_raddr = 4'd15;
      tick();
      check("a_top_data",  32'(a_rd_data),  32'h3C);
      check("a_top_valid", 32'(a_rd_valid), 32'h1);
      a_raddr = 4'd0;
      tick();
      check("a_zero_data",  32'(a_rd_data),  32'hC3);
      check("a_zero_valid", 32'(a_rd_valid), 32'h1);
      a_rd_en = 1'b0;
      tick();
      check("a_b2b_end", 32'(a_rd_valid), 32'h0);

      // Old-data collision, then write commits.
      a_write(4'd7, 8'h11);
      a_wr_en = 1'b1; a_waddr = 4'd7; a_wr_data = 8'h22; a_wr_be = 1'b1;
      a_rd_en = 1'b1; a_raddr = 4'd7;
      tick();
      a_wr_en = 1'b0; a_rd_en = 1'b0;
      check("a_coll_old", 32'(a_rd_data), 32'h11);
      a_read(4'd7);
      check("a_coll_commit", 32'(a_rd_data), 32'h22);

      // Byte-enable partial write on the 16-bit instance.
      b_write(4'd5, 16'h1234, 2'b11, 2'b00);
      b_write(4'd5, 16'hABCD, 2'b01, 2'b00);
      b_read(4'd5);
      check("b_be_lat1", 32'(b_rd_valid), 32'h0);
      tick();
      check("b_be_data",  32'(b_rd_data),  32'h12CD);
      check("b_be_valid", 32'(b_rd_valid), 32'h1);
      tick();
      check("b_be_pulse", 32'(b_rd_valid), 32'h0);

      // Write-through collision: full and per-lane merge.
      b_write(4'd7, 16'h0011, 2'b11, 2'b00);
      b_wr_en = 1'b1; b_waddr = 4'd7; b_wr_data = 16'h0022; b_wr_be = 2'b11;
      b_rd_en = 1'b1; b_raddr = 4'd7;
      tick();
      b_wr_en = 1'b0; b_rd_en = 1'b0;
      tick();
      check("b_coll_new", 32'(b_rd_data), 32'h0022);
      b_read(4'd7);
      tick();
      check("b_coll_commit", 32'(b_rd_data), 32'h0022);
      b_wr_en = 1'b1; b_waddr = 4'd7; b_wr_data = 16'hAB00; b_wr_be = 2'b10;
      b_rd_en = 1'b1; b_raddr = 4'd7;
      tick();
      b_wr_en = 1'b0; b_rd_en = 1'b0;
      tick();
      check("b_coll_merge", 32'(b_rd_data), 32'hAB22);

      // Fill with value = address, then back-to-back reads across the wrap.
      for (int i = 0; i < 16; i++) begin
         b_write(4'(i), 16'(i), 2'b11, 2'b00);
      end
      b_rd_en = 1'b1; b_raddr = 4'd15;
      tick();
      check("b_pipe_lat", 32'(b_rd_valid), 32'h0);
      b_raddr = 4'd0;
      tick();
      check("b_pipe0_data",  32'(b_rd_data),  32'h000F);
      check("b_pipe0_valid", 32'(b_rd_valid), 32'h1);
      b_raddr = 4'd1;
      tick();
      check("b_pipe1_data", 32'(b_rd_data), 32'h0000);
      b_rd_en = 1'b0;
      tick();
      check("b_pipe2_data",  32'(b_rd_data),  32'h0001);
      check("b_pipe2_valid", 32'(b_rd_valid), 32'h1);
      tick();
      check("b_pipe_end", 32'(b_rd_valid), 32'h0);

      // A write after the read is issued does not alter the in-flight word.
      b_read(4'd3);
      b_wr_en = 1'b1; b_waddr = 4'd3; b_wr_data = 16'h5555; b_wr_be = 2'b11;
      tick();
      b_wr_en = 1'b0;
      check("b_inflight", 32'(b_rd_data), 32'h0003);

      // Reset pulsed behind a lone read kills it.
      b_read(4'd4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("b_rstpulse_valid", 32'(b_rd_valid), 32'h0);
      check("b_rstpulse_data",  32'(b_rd_data),  32'h0);
      tick();
      check("b_rstpulse_after", 32'(b_rd_valid), 32'h0);
      b_read(4'd1);
      tick();
      check("b_post_rst_data",  32'(b_rd_data),  32'h0001);
      check("b_post_rst_valid", 32'(b_rd_valid), 32'h1);

      // Parity test hook.
      a_wr_en = 1'b1; a_waddr = 4'd2; a_wr_data = 8'h5A; a_wr_be = 1'b1; a_wr_par_flip = 1'b1;
      tick();
      a_wr_en = 1'b0; a_wr_par_flip = 1'b0;
      a_read(4'd2);
      check("a_perr_flip",  32'(a_rd_par_err), 32'(PAR_EXP));
      check("a_perr_valid", 32'(a_rd_valid),   32'h1);
      tick();
      check("a_perr_idle", 32'(a_rd_par_err), 32'h0);
      a_write(4'd2, 8'h5A);
      a_read(4'd2);
      check("a_perr_clean", 32'(a_rd_par_err), 32'h0);
      check("a_perr_data",  32'(a_rd_data),    32'h5A);

      b_write(4'd9, 16'h1357, 2'b11, 2'b10);
      b_read(4'd9);
      tick();
      check("b_perr_flip", 32'(b_rd_par_err), 32'(PAR_EXP));
      check("b_perr_data", 32'(b_rd_data),    32'h1357);
      b_wr_en = 1'b1; b_waddr = 4'd9; b_wr_data = 16'h2468; b_wr_be = 2'b11; b_wr_par_flip = 2'b00;
      b_rd_en = 1'b1; b_raddr = 4'd9;
      tick();
      b_wr_en = 1'b0; b_rd_en = 1'b0;
      tick();
      check("b_perr_fwd",      32'(b_rd_par_err), 32'h0);
      check("b_perr_fwd_data", 32'(b_rd_data),    32'h2468);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
